// File: rtl/outbox_fifo_if.sv
// Handshake bundle between the CPU-side producer / display-side consumer and
// the outbox FIFO. The FIFO uses the slave view; whoever drives pushes, pops
// and flushes uses the master view.
interface outbox_fifo_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic             i_wr;
    logic [WIDTH-1:0] i_data;
    logic             i_ready;
    logic             i_clr;
    logic             o_full;
    logic             o_empty;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic [AW:0]      o_count;
    logic             o_ovf;

    modport master (
        output i_wr, i_data, i_ready, i_clr,
        input  o_full, o_empty, o_valid, o_data, o_count, o_ovf
    );

    modport slave (
        input  i_wr, i_data, i_ready, i_clr,
        output o_full, o_empty, o_valid, o_data, o_count, o_ovf
    );
endinterface

// File: rtl/outbox_fifo.sv
// Outbox FIFO: first-word-fall-through queue between register R (push side)
// and the display/UART consumer (pop side). Pointers carry one extra bit so
// full and empty are distinguishable without a separate counter.
module outbox_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input logic         clk,
    input logic         i_rst,
    outbox_fifo_if.slave bus
);
    localparam int DEPTH = 1 << AW;

    // Storage is never cleared; only the pointers define what is queued.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        ovf_reg;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // Flags and handshake decisions, all derived from registered pointers.
    always_comb begin
        empty = (wr_ptr_reg == rd_ptr_reg);
        full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
        // A pop frees a slot on the same edge, so a full FIFO can still
        // accept a push when the consumer is taking the head word.
        pop   = !empty && bus.i_ready;
        push  = bus.i_wr && (!full || pop);
        drop  = bus.i_wr && full && !pop;
    end

    // Pointer and sticky-overflow state; flush wins over push and pop.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            ovf_reg    <= 1'b0;
        end else if (bus.i_clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (drop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    // Data write port; a flush on the same edge discards the push.
    always_ff @(posedge clk) begin
        if (push && !bus.i_clr) begin
            mem[wr_ptr_reg[AW-1:0]] <= bus.i_data;
        end
    end

    // The head word is read combinationally so it is visible as soon as
    // o_valid rises; it only moves when rd_ptr advances on a pop.
    assign bus.o_data  = mem[rd_ptr_reg[AW-1:0]];
    assign bus.o_valid = !empty;
    assign bus.o_empty = empty;
    assign bus.o_full  = full;
    assign bus.o_count = wr_ptr_reg - rd_ptr_reg;
    assign bus.o_ovf   = ovf_reg;
endmodule

// File: tb/tb_outbox_fifo.sv
// Bench for outbox_fifo: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_outbox_fifo;
    localparam int WIDTH = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic i_rst = 1'b0;

    outbox_fifo_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    outbox_fifo #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk  (clk),
        .i_rst(i_rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queued words in order, plus the sticky overflow bit.
    logic [WIDTH-1:0] q[$];
    logic             m_ovf = 1'b0;

    // One clock edge: drive inputs, advance the model by the FIFO rules,
    // then settle 1 time unit past the edge.
    task automatic cyc(input logic wr, input logic [WIDTH-1:0] d,
                       input logic rdy, input logic clr);
        logic m_pop;
        logic m_full;
        bus.i_wr    = wr;
        bus.i_data  = d;
        bus.i_ready = rdy;
        bus.i_clr   = clr;
        m_pop  = (q.size() > 0) && rdy;
        m_full = (q.size() == DEPTH);
        @(posedge clk);
        if (clr) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            if (wr && m_full && !m_pop) m_ovf = 1'b1;
            if (m_pop) void'(q.pop_front());
            if (wr && (!m_full || m_pop)) q.push_back(d);
        end
        #1;
        bus.i_wr    = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_clr   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        i_rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.i_wr = 1'b0; bus.i_data = '0; bus.i_ready = 1'b0; bus.i_clr = 1'b0;
        @(negedge clk);
        i_rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 || bus.o_valid !== 1'b0 ||
            bus.o_count !== 5'd0 || bus.o_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: empty=%b full=%b valid=%b count=%0d ovf=%b, need 1 0 0 0 0",
                     bus.o_empty, bus.o_full, bus.o_valid, bus.o_count, bus.o_ovf);
        end else $display("reset_state ok");
        @(negedge clk);
        i_rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic test_first_push();
        cyc(1'b1, 8'h05, 1'b0, 1'b0);
        n_cmp++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h05 || bus.o_count !== 5'd1 ||
            bus.o_empty !== 1'b0) begin
            n_err++;
            $display("FAIL first_push: valid=%b data=%h count=%0d empty=%b, need 1 05 1 0",
                     bus.o_valid, bus.o_data, bus.o_count, bus.o_empty);
        end else $display("first_push ok data=%h", bus.o_data);
    endtask

    task automatic test_fill_overflow();
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        n_cmp++;
        if (bus.o_full !== 1'b1 || bus.o_count !== 5'd16 || bus.o_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL fill: full=%b count=%0d ovf=%b, need 1 16 0",
                     bus.o_full, bus.o_count, bus.o_ovf);
        end else $display("fill ok count=%0d", bus.o_count);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        n_cmp++;
        if (bus.o_ovf !== 1'b1 || bus.o_data !== 8'h00 || bus.o_count !== 5'd16) begin
            n_err++;
            $display("FAIL overflow_drop: ovf=%b head=%h count=%0d, need 1 00 16",
                     bus.o_ovf, bus.o_data, bus.o_count);
        end else $display("overflow_drop ok");
    endtask

    task automatic test_full_push_pop();
        n_cmp++;
        if (bus.o_data !== 8'h00) begin
            n_err++;
            $display("FAIL full_pp_head: head=%h, need 00", bus.o_data);
        end
        cyc(1'b1, 8'h10, 1'b1, 1'b0);
        n_cmp++;
        if (bus.o_count !== 5'd16 || bus.o_ovf !== 1'b1 || bus.o_data !== 8'h01 ||
            bus.o_full !== 1'b1) begin
            n_err++;
            $display("FAIL full_push_pop: count=%0d ovf=%b head=%h full=%b, need 16 1 01 1",
                     bus.o_count, bus.o_ovf, bus.o_data, bus.o_full);
        end else $display("full_push_pop ok head=%h", bus.o_data);
        // Drain and confirm the replacement word came out last, in order.
        for (int i = 1; i <= DEPTH; i++) begin
            n_cmp++;
            if (bus.o_valid !== 1'b1 || bus.o_data !== 8'(i)) begin
                n_err++;
                $display("FAIL drain_order[%0d]: valid=%b data=%h, need 1 %h",
                         i, bus.o_valid, bus.o_data, 8'(i));
            end
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        n_cmp++;
        if (bus.o_empty !== 1'b1) begin
            n_err++;
            $display("FAIL drain_empty: empty=%b, need 1", bus.o_empty);
        end else $display("drain ok");
    endtask

    task automatic test_stream();
        int next_in = 0;
        int exp_out = 0;
        int cycles  = 0;
        logic rdy;
        logic wr;
        logic [WIDTH-1:0] held;
        logic stalled;
        do_reset();
        stalled = 1'b0;
        held = '0;
        while (exp_out < 40 && cycles < 600) begin
            cycles++;
            wr  = (next_in < 40) && (q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            if (stalled && bus.o_valid) begin
                n_cmp++;
                if (bus.o_data !== held) begin
                    n_err++;
                    $display("FAIL stall_stable: data=%h, need %h", bus.o_data, held);
                end
            end
            if (bus.o_valid && rdy) begin
                n_cmp++;
                if (bus.o_data !== 8'(exp_out)) begin
                    n_err++;
                    $display("FAIL stream_order: data=%h, need %h", bus.o_data, 8'(exp_out));
                end else $display("stream pop %0d", exp_out);
                exp_out++;
            end
            stalled = bus.o_valid && !rdy;
            held    = bus.o_data;
            cyc(wr, 8'(next_in), rdy, 1'b0);
            if (wr) next_in++;
        end
        n_cmp++;
        if (exp_out != 40 || bus.o_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL stream_done: popped=%0d ovf=%b, need 40 0", exp_out, bus.o_ovf);
        end
    endtask

    task automatic test_empty_push_pop();
        do_reset();
        cyc(1'b1, 8'h33, 1'b1, 1'b0);
        n_cmp++;
        if (bus.o_count !== 5'd1 || bus.o_data !== 8'h33 || bus.o_valid !== 1'b1) begin
            n_err++;
            $display("FAIL empty_push_pop: count=%0d data=%h valid=%b, need 1 33 1",
                     bus.o_count, bus.o_data, bus.o_valid);
        end else $display("empty_push_pop ok");
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (bus.o_empty !== 1'b1 || bus.o_count !== 5'd0) begin
            n_err++;
            $display("FAIL empty_pop_after: empty=%b count=%0d, need 1 0",
                     bus.o_empty, bus.o_count);
        end else $display("empty_pop_after ok");
    endtask

    task automatic test_clear_and_async_reset();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (bus.o_count !== 5'd5 || bus.o_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL clr_setup: count=%0d ovf=%b, need 5 1", bus.o_count, bus.o_ovf);
        end
        // Push and pop on the flush edge must both be discarded.
        cyc(1'b1, 8'h77, 1'b1, 1'b1);
        n_cmp++;
        if (bus.o_count !== 5'd0 || bus.o_ovf !== 1'b0 || bus.o_empty !== 1'b1) begin
            n_err++;
            $display("FAIL clr: count=%0d ovf=%b empty=%b, need 0 0 1",
                     bus.o_count, bus.o_ovf, bus.o_empty);
        end else $display("clr ok");
        for (int i = 0; i < 17; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        // Reset between edges: flags must clear before any clock edge.
        #1;
        i_rst = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        #1;
        n_cmp++;
        if (bus.o_count !== 5'd0 || bus.o_ovf !== 1'b0 || bus.o_empty !== 1'b1 ||
            bus.o_full !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: count=%0d ovf=%b empty=%b full=%b, need 0 0 1 0",
                     bus.o_count, bus.o_ovf, bus.o_empty, bus.o_full);
        end else $display("async_reset ok");
        @(negedge clk);
        i_rst = 1'b0;
        // First edge after release must accept a push.
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        n_cmp++;
        if (bus.o_count !== 5'd1 || bus.o_data !== 8'h5A) begin
            n_err++;
            $display("FAIL reset_release_push: count=%0d data=%h, need 1 5a",
                     bus.o_count, bus.o_data);
        end else $display("reset_release_push ok");
    endtask

    task automatic test_random();
        logic wr;
        logic rdy;
        logic clr;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            wr  = ($urandom_range(0, 9) < 6);
            rdy = ($urandom_range(0, 9) < 4);
            clr = ($urandom_range(0, 99) == 0);
            cyc(wr, 8'($urandom), rdy, clr);
            n_cmp++;
            if (bus.o_count !== 5'(q.size()) || bus.o_ovf !== m_ovf ||
                bus.o_empty !== (q.size() == 0) || bus.o_full !== (q.size() == DEPTH) ||
                bus.o_valid !== (q.size() != 0) ||
                (q.size() != 0 && bus.o_data !== q[0])) begin
                n_err++;
                $display("FAIL random[%0d]: count=%0d ovf=%b data=%h, need %0d %b %h",
                         n, bus.o_count, bus.o_ovf, bus.o_data, q.size(), m_ovf,
                         (q.size() != 0) ? q[0] : 8'h00);
            end
        end
        $display("random traffic done, model depth %0d", q.size());
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_fill_overflow();
        test_full_push_pop();
        test_stream();
        test_empty_push_pop();
        test_clear_and_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/outbox_fifo.md
OUTBOX_FIFO -- requirements
Module: outbox_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data word width (matches the CPU register R).
REQ-002 The block SHALL have parameter AW, default 4, meaning log2 of the storage depth (DEPTH = 2^AW = 16 entries).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1, the reset, asynchronous and active-high.
REQ-005 The block SHALL have port i_wr, input, 1, the push strobe, driven by the control unit wO.
REQ-006 The block SHALL have port i_data, input, WIDTH, the push data, taken from register R.
REQ-007 The block SHALL have port o_full, output, 1, the full flag, fed to the control unit outFull.
REQ-008 The block SHALL have port o_empty, output, 1, the empty flag.
REQ-009 The block SHALL have port o_valid, output, 1, meaning the head word is present on o_data.
REQ-010 The block SHALL have port o_data, output, WIDTH, the head word (first-word-fall-through).
REQ-011 The block SHALL have port i_ready, input, 1, the consumer accept signal (display/UART side).
REQ-012 The block SHALL have port i_clr, input, 1, a synchronous flush.
REQ-013 The block SHALL have port o_count, output, AW+1, the current occupancy, 0..DEPTH.
REQ-014 The block SHALL have port o_ovf, output, 1, a sticky overflow error flag.

Function
REQ-015 Storage SHALL be a DEPTH x WIDTH array with AW+1-bit write and read pointers; the MSB distinguishes full from empty.
REQ-016 o_empty SHALL equal (wr_ptr == rd_ptr), and o_full SHALL equal (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) with differing MSBs; both SHALL be derived from registered pointers only.
REQ-017 o_count SHALL equal wr_ptr - rd_ptr modulo 2^(AW+1).
REQ-018 o_valid SHALL equal !o_empty, and o_data SHALL equal mem[rd_ptr[AW-1:0]] combinationally; o_data is don't-care while o_valid=0.
REQ-019 A pop SHALL occur on a rising edge when o_valid && i_ready; rd_ptr increments by 1 and wraps naturally.
REQ-020 A push SHALL occur on a rising edge when i_wr && (!o_full || pop); i_data is written at wr_ptr and wr_ptr increments by 1.
REQ-021 For a push while full with a simultaneous pop, the push SHALL be accepted, count SHALL stay DEPTH, and o_ovf SHALL be unchanged.
REQ-022 For a push while full without a pop, the data SHALL be dropped, the pointers SHALL be unchanged, and o_ovf SHALL be set to 1 on that edge and stay set until reset or i_clr.
REQ-023 For a push while empty with i_ready=1, the pop SHALL be ignored because o_valid=0, the push SHALL be accepted, and o_valid=1 and count=1 SHALL hold on the next cycle (latency push->o_valid = 1 cycle).
REQ-024 A pop SHALL never occur while empty; rd_ptr SHALL never pass wr_ptr.
REQ-025 i_clr=1 SHALL on the next edge set wr_ptr=rd_ptr=0 and o_ovf=0; i_clr has priority over push and pop on the same edge.
REQ-026 Memory contents SHALL NOT be cleared by reset or i_clr.
REQ-027 o_data SHALL hold stable while o_valid=1 and i_ready=0 (a consumer-stall guarantee).
REQ-028 Pointer wrap at DEPTH SHALL be transparent; the order of words out SHALL equal the order of words in across any number of wraps.

Reset
REQ-029 While i_rst=1, asynchronously, the block SHALL hold wr_ptr=0, rd_ptr=0 and o_ovf=0, giving o_empty=1, o_full=0, o_valid=0 and o_count=0.
REQ-030 On deassertion of i_rst, the block SHALL accept a push at the first rising edge that samples i_rst=0.
REQ-031 Reset asserted mid-operation SHALL discard all queued words immediately, without waiting for a clock edge.

Verification
REQ-032 Reset, then push 0x05 with i_ready=0 -> next cycle o_valid=1, o_data=0x05, o_count=1, o_empty=0.
REQ-033 Push 16 words 0x00..0x0F with i_ready=0 -> o_full=1, o_count=16; a 17th push (0xAA) -> dropped, o_ovf=1, head still 0x00.
REQ-034 From full, drive i_wr=1 (data 0x10) and i_ready=1 for one cycle -> 0x00 popped, 0x10 accepted, o_count=16, o_ovf unchanged.
REQ-035 Push/pop 40 words (0..39) with random i_ready stalls -> output sequence 0..39 in order, o_data stable during stalls, no drops.
REQ-036 Empty FIFO with i_ready=1 and i_wr=1 (0x33) on the same edge -> o_count=1, o_data=0x33; the next edge pops it -> o_empty=1.
REQ-037 With 5 words queued and o_ovf=1, pulse i_clr -> o_count=0, o_ovf=0; separately, assert i_rst between edges -> flags reset immediately, before the next edge.
